// File: rtl/motion_sequencer.sv
// Command stage for pulse_generator: quarter turns, continuous runs and stops, with speed
// ramping driven by step_pulse feedback and half-step absolute position tracking.
module motion_sequencer #(
  parameter int unsigned STEPS_PER_REV = 200,
  parameter int unsigned RAMP_STEPS    = 8,
  parameter int unsigned POS_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_quarter,
  input  logic             run_continuous,
  input  logic             stop_req,
  input  logic             direction,
  input  logic             step_mode,
  input  logic [2:0]       target_speed,
  input  logic             step_pulse,
  output logic             enable,
  output logic             dir_o,
  output logic             step_size,
  output logic [2:0]       speed_value,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  localparam int unsigned PosMod = 2 * STEPS_PER_REV;
  localparam int unsigned RemW   = $clog2(STEPS_PER_REV / 2 + 1);
  localparam int unsigned RampW  = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
  localparam logic [RemW-1:0]  RemFull  = RemW'(STEPS_PER_REV / 4);
  localparam logic [RemW-1:0]  RemHalf  = RemW'(STEPS_PER_REV / 2);
  localparam logic [RampW-1:0] RampLast = RampW'(RAMP_STEPS - 1);

  typedef enum logic [1:0] {StIdle, StRunQ, StRunC, StDecel} state_e;

  state_e           state_q, state_d;
  logic [RemW-1:0]  rem_q, rem_d, rem_dec;
  logic [RampW-1:0] ramp_q, ramp_d;
  logic             en_d, dir_d, size_d, busy_d, done_d;
  logic [2:0]       speed_d, tgt, ramped;
  logic [POS_W-1:0] pos_d;
  logic             step_ev, ramp_tick;
  logic [31:0]      pos_ext, amt, pos_step, brake_dist;

  assign step_ev   = step_pulse && enable;
  assign ramp_tick = step_ev && (ramp_q == RampLast);
  assign rem_dec   = rem_q - RemW'(1);

  // Speed after one ramp tick in a running state; a quarter turn brakes once the
  // remaining distance no longer covers the ramp-down at the current level.
  always_comb begin
    tgt        = (target_speed > 3'd5) ? 3'd5 : target_speed;
    brake_dist = 32'(speed_value) * RAMP_STEPS;
    ramped     = speed_value;
    if (state_q == StRunQ && 32'(rem_dec) <= brake_dist) begin
      if (speed_value != 3'd0) ramped = speed_value - 3'd1;
    end else if (speed_value < tgt) begin
      ramped = speed_value + 3'd1;
    end else if (speed_value > tgt) begin
      ramped = speed_value - 3'd1;
    end
  end

  always_comb begin
    amt     = step_size ? 32'd2 : 32'd1;
    pos_ext = 32'(position);
    if (dir_o) begin
      pos_step = (pos_ext + amt >= PosMod) ? pos_ext + amt - PosMod : pos_ext + amt;
    end else begin
      pos_step = (pos_ext >= amt) ? pos_ext - amt : pos_ext + PosMod - amt;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ramp_d  = ramp_q;
    en_d    = enable;
    dir_d   = dir_o;
    size_d  = step_size;
    speed_d = speed_value;
    done_d  = 1'b0;
    pos_d   = position;
    if (step_ev) begin
      pos_d  = POS_W'(pos_step);
      ramp_d = (ramp_q == RampLast) ? '0 : ramp_q + RampW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start_quarter || run_continuous) begin
          state_d = start_quarter ? StRunQ : StRunC;
          rem_d   = step_mode ? RemFull : RemHalf;
          dir_d   = direction;
          size_d  = step_mode;
          speed_d = 3'd0;
          ramp_d  = '0;
          en_d    = 1'b1;
        end
      end
      StRunQ: begin
        if (step_ev) rem_d = rem_dec;
        if (step_ev && rem_dec == '0) begin
          en_d    = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          if (ramp_tick) speed_d = ramped;
          if (stop_req) state_d = StDecel;
        end
      end
      StRunC: begin
        if (ramp_tick) speed_d = ramped;
        if (stop_req || !run_continuous) state_d = StDecel;
      end
      StDecel: begin
        if (ramp_tick) begin
          if (speed_value != 3'd0) begin
            speed_d = speed_value - 3'd1;
          end else begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      ramp_q      <= '0;
      enable      <= 1'b0;
      dir_o       <= 1'b0;
      step_size   <= 1'b1;
      speed_value <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      position    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      ramp_q      <= ramp_d;
      enable      <= en_d;
      dir_o       <= dir_d;
      step_size   <= size_d;
      speed_value <= speed_d;
      busy        <= busy_d;
      done        <= done_d;
      position    <= pos_d;
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Randomized scoreboard bench for motion_sequencer: stimulus tasks push expected output
// snapshots from a behavioural model, a negedge monitor pops and compares them.
module tb_motion_sequencer;
  localparam int SPR  = 200;
  localparam int RAMP = 8;
  localparam int MOD  = 2 * SPR;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_quarter = 1'b0, run_continuous = 1'b0, stop_req = 1'b0;
  logic        direction = 1'b0, step_mode = 1'b1, step_pulse = 1'b0;
  logic [2:0]  target_speed = 3'd0;
  logic        enable, dir_o, step_size, busy, done;
  logic [2:0]  speed_value;
  logic [15:0] position;

  always #5 clk = ~clk;

  motion_sequencer #(.STEPS_PER_REV(SPR), .RAMP_STEPS(RAMP), .POS_W(16)) dut (
    .clk(clk), .reset(reset), .start_quarter(start_quarter), .run_continuous(run_continuous),
    .stop_req(stop_req), .direction(direction), .step_mode(step_mode),
    .target_speed(target_speed), .step_pulse(step_pulse), .enable(enable), .dir_o(dir_o),
    .step_size(step_size), .speed_value(speed_value), .busy(busy), .done(done),
    .position(position)
  );

  typedef struct {int pos; int speed; int en; int dir; int size; int busy; int done;} snap_t;
  snap_t exp_q[$];
  snap_t e_mon;
  int total = 0, bad = 0;
  logic chk_req = 1'b0, chk_fired = 1'b0;

  // Model: mode 0 idle, 1 quarter turn, 2 continuous, 3 stopping
  int m_mode, m_pos, m_speed, m_ramp, m_rem, m_dir, m_size, m_en, m_done;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_speed = 0; m_ramp = 0; m_rem = 0;
    m_dir = 0; m_size = 1; m_en = 0; m_done = 0;
  endfunction

  function automatic void push_snap();
    snap_t s;
    s.pos = m_pos; s.speed = m_speed; s.en = m_en; s.dir = m_dir; s.size = m_size;
    s.busy = (m_mode != 0) ? 1 : 0; s.done = m_done;
    exp_q.push_back(s);
  endfunction

  function automatic void model_finish();
    m_en = 0; m_done = 1; m_mode = 0;
  endfunction

  function automatic void apply_step(input int tgt_raw);
    int amt, tgt;
    bit tick;
    m_done = 0;
    if (m_en == 0) return;
    amt   = m_size ? 2 : 1;
    m_pos = m_dir ? (m_pos + amt) % MOD : (m_pos - amt + MOD) % MOD;
    tick  = (m_ramp == RAMP - 1);
    m_ramp = tick ? 0 : m_ramp + 1;
    tgt   = (tgt_raw > 5) ? 5 : tgt_raw;
    if (m_mode == 1) begin
      m_rem--;
      if (m_rem == 0) model_finish();
      else if (tick) begin
        if (m_rem <= m_speed * RAMP) m_speed = (m_speed > 0) ? m_speed - 1 : 0;
        else if (m_speed < tgt) m_speed++;
        else if (m_speed > tgt) m_speed--;
      end
    end else if (m_mode == 2 && tick) begin
      if (m_speed < tgt) m_speed++;
      else if (m_speed > tgt) m_speed--;
    end else if (m_mode == 3 && tick) begin
      if (m_speed > 0) m_speed--;
      else model_finish();
    end
  endfunction

  always @(posedge clk) chk_fired <= chk_req;

  always @(negedge clk) begin
    if (!reset) begin
      if (chk_fired) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_underflow: got an output cycle, expected none pending");
        end else begin
          e_mon = exp_q.pop_front();
          check("position", int'(position), e_mon.pos);
          check("speed_value", int'(speed_value), e_mon.speed);
          check("enable", int'(enable), e_mon.en);
          check("dir_o", int'(dir_o), e_mon.dir);
          check("step_size", int'(step_size), e_mon.size);
          check("busy", int'(busy), e_mon.busy);
          check("done", int'(done), e_mon.done);
        end
      end else begin
        check("stray_done", int'(done), 0);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_step(input int tgt);
    target_speed = tgt[2:0];
    step_pulse = 1'b1; chk_req = 1'b1;
    apply_step(tgt); push_snap();
    @(posedge clk); #1 step_pulse = 1'b0; chk_req = 1'b0;
  endtask

  task automatic cmd_quarter(input int d, input int sm, input int also_run);
    direction = d[0]; step_mode = sm[0]; start_quarter = 1'b1; run_continuous = also_run[0];
    chk_req = 1'b1; m_done = 0;
    if (m_mode == 0) begin
      m_mode = 1; m_dir = d; m_size = sm; m_speed = 0; m_ramp = 0; m_en = 1;
      m_rem = sm ? SPR / 4 : SPR / 2;
    end
    push_snap();
    @(posedge clk); #1 start_quarter = 1'b0; chk_req = 1'b0;
  endtask

  task automatic cmd_run(input int d, input int sm);
    direction = d[0]; step_mode = sm[0]; run_continuous = 1'b1;
    chk_req = 1'b1; m_done = 0;
    if (m_mode == 0) begin
      m_mode = 2; m_dir = d; m_size = sm; m_speed = 0; m_ramp = 0; m_en = 1;
    end
    push_snap();
    @(posedge clk); #1 chk_req = 1'b0;
  endtask

  task automatic cmd_drop();
    run_continuous = 1'b0; chk_req = 1'b1; m_done = 0;
    if (m_mode == 2) m_mode = 3;
    push_snap();
    @(posedge clk); #1 chk_req = 1'b0;
  endtask

  task automatic cmd_stop();
    stop_req = 1'b1; chk_req = 1'b1; m_done = 0;
    if (m_mode == 1 || m_mode == 2) m_mode = 3;
    push_snap();
    @(posedge clk); #1 stop_req = 1'b0; chk_req = 1'b0;
  endtask

  // tgt < 0 picks a fresh random target for every step
  task automatic run_until_idle(input int tgt, input int max_steps, input int rand_gap,
                                output int n);
    n = 0;
    while (m_mode != 0 && n < max_steps) begin
      drive_step((tgt < 0) ? int'($urandom_range(0, 7)) : tgt);
      n++;
      if (rand_gap != 0) idle_cycles($urandom_range(0, 3));
    end
    if (m_mode != 0) begin
      total++; bad++;
      $display("FAIL move_timeout: got %0d steps without completion, expected completion", n);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    idle_cycles(2);
    check("rst_enable", int'(enable), 0);
    check("rst_dir_o", int'(dir_o), 0);
    check("rst_step_size", int'(step_size), 1);
    check("rst_speed", int'(speed_value), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_position", int'(position), 0);
    reset = 1'b0;
    idle_cycles(2);
    drive_step(3);  // ignored while idle

    // Full-step forward quarter turn
    cmd_quarter(1, 1, 0);
    run_until_idle(5, 200, 0, n);
    check("q_full_steps", n, 50);
    check("q_full_done", int'(done), 1);
    check("q_full_enable", int'(enable), 0);
    check("q_full_position", int'(position), 100);
    idle_cycles(2);

    // Reset in the middle of a quarter turn
    cmd_quarter(0, 1, 0);
    repeat (10) drive_step(5);
    @(negedge clk); #1 reset = 1'b1;
    #1;
    check("arst_enable", int'(enable), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_position", int'(position), 0);
    check("arst_speed", int'(speed_value), 0);
    check("arst_step_size", int'(step_size), 1);
    model_reset();
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(3);

    // Half-step reverse quarter turn from position 0
    cmd_quarter(0, 0, 0);
    run_until_idle(4, 300, 0, n);
    check("q_half_steps", n, 100);
    check("q_half_position", int'(position), 300);
    idle_cycles(2);

    // Continuous run ramp-up and ramp-down
    cmd_run(1, 1);
    repeat (8) drive_step(5);
    check("c_speed_p8", int'(speed_value), 1);
    repeat (32) drive_step(5);
    check("c_speed_p40", int'(speed_value), 5);
    cmd_drop();
    run_until_idle(5, 200, 0, n);
    check("c_decel_steps", n, 48);
    idle_cycles(2);

    // Over-range target, start_quarter with run_continuous also high
    cmd_quarter(1, 1, 1);
    cmd_drop();
    run_until_idle(7, 200, 1, n);
    check("q_clamp_steps", n, 50);

    // start_quarter while busy is ignored
    cmd_quarter(1, 1, 0);
    repeat (12) drive_step(6);
    cmd_quarter(0, 0, 0);
    run_until_idle(6, 200, 0, n);
    check("q_ignore_steps", n, 38);

    // stop_req in a quarter turn
    cmd_quarter(0, 1, 0);
    repeat (20) drive_step(5);
    cmd_stop();
    run_until_idle(5, 200, 1, n);
    idle_cycles(2);

    // Randomized moves
    for (int k = 0; k < 14; k++) begin
      repeat ($urandom_range(0, 2)) drive_step($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        cmd_quarter($urandom_range(0, 1), $urandom_range(0, 1), 0);
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 20)) drive_step($urandom_range(0, 7));
          cmd_stop();
        end
      end else begin
        cmd_run($urandom_range(0, 1), $urandom_range(0, 1));
        repeat ($urandom_range(0, 60)) begin
          drive_step($urandom_range(0, 7));
          idle_cycles($urandom_range(0, 2));
        end
        cmd_drop();
      end
      run_until_idle(-1, 400, 1, n);
      idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(3);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
